// File: rtl/half_adder_pkg.sv
// Shared constants and types for the half-adder carry monitor cell.
package half_adder_pkg;

   localparam int CNT_W_DEFAULT = 8;

   typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

endpackage

// File: rtl/half_adder_carry_if.sv
// Signal bundle for the half-adder carry monitor: addend inputs plus sum/carry observability.
interface half_adder_carry_if
   import half_adder_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) ();

   logic             a;
   logic             b;
   logic             co;
   logic             s;
   logic             co_q;
   logic             co_rise;
   logic [CNT_W-1:0] carry_cnt;
   logic             cnt_sat;

   modport master (
      output a, b,
      input  co, s, co_q, co_rise, carry_cnt, cnt_sat
   );

   modport slave (
      input  a, b,
      output co, s, co_q, co_rise, carry_cnt, cnt_sat
   );

endinterface

// File: rtl/sat_counter.sv
// Width-parameterized saturating up-counter with increment enable and all-ones flag.
module sat_counter
   import half_adder_pkg::*;
#(
   parameter int W = CNT_W_DEFAULT
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt,
   output logic         o_sat
);

   logic [W-1:0] r_cnt;

   assign o_sat = &r_cnt;
   assign o_cnt = r_cnt;

   // Holding at all-ones instead of wrapping keeps the count monotonic.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_inc && !o_sat) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/half_adder_carry.sv
// Half adder with registered carry, carry rising-edge pulse and saturating carry-event count.
// Define HALF_ADDER_IN_SYNC_EN to put 2-flop synchronizers on a/b ahead of the registered path.
module half_adder_carry
   import half_adder_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   half_adder_carry_if.slave bus
);

   logic w_co_reg;
   logic w_inc;
   logic r_co_q;
   logic r_co_rise;

   assign bus.co = bus.a & bus.b;
   assign bus.s  = bus.a ^ bus.b;

`ifdef HALF_ADDER_IN_SYNC_EN
   logic [1:0] r_a_sync;
   logic [1:0] r_b_sync;

   // Only the registered path sees the synchronized copies; co/s stay raw.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_a_sync <= '0;
         r_b_sync <= '0;
      end else begin
         r_a_sync <= {r_a_sync[0], bus.a};
         r_b_sync <= {r_b_sync[0], bus.b};
      end
   end

   assign w_co_reg = r_a_sync[1] & r_b_sync[1];
`else
   assign w_co_reg = bus.co;
`endif

   assign w_inc = w_co_reg & ~r_co_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_co_q    <= 1'b0;
         r_co_rise <= 1'b0;
      end else begin
         r_co_q    <= w_co_reg;
         r_co_rise <= w_inc;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .i_clk (clock),
      .i_rst (reset),
      .i_inc (w_inc),
      .o_cnt (bus.carry_cnt),
      .o_sat (bus.cnt_sat)
   );

   assign bus.co_q    = r_co_q;
   assign bus.co_rise = r_co_rise;

endmodule

// File: tb/tb_half_adder_carry.sv
// Self-checking bench for half_adder_carry: directed timing/saturation/reset cases plus a randomized model check.
module tb_half_adder_carry;
   import half_adder_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses8  = 0;

   half_adder_carry_if #(.CNT_W(8)) bus8 ();
   half_adder_carry_if #(.CNT_W(2)) bus2 ();

   half_adder_carry #(.CNT_W(8)) dut8 (
      .clock (clock),
      .reset (reset),
      .bus   (bus8.slave)
   );

   half_adder_carry #(.CNT_W(2)) dut2 (
      .clock (clock),
      .reset (reset),
      .bus   (bus2.slave)
   );

   initial forever #5 clock = ~clock;

   always @(negedge clock) begin
      if (bus8.co_rise) pulses8++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic at_time(input longint t);
      if (t > longint'($time)) #(t - longint'($time));
   endtask

   initial begin
      int m_coq, m_rise, total, exp_cnt, c, eff, sum2, p0;
      int hist[$];

      bus8.a = 1'b0; bus8.b = 1'b0;
      bus2.a = 1'b0; bus2.b = 1'b0;
      reset  = 1'b1;

`ifndef HALF_ADDER_IN_SYNC_EN
      // Timed stimulus from time 0 with a 10-unit clock (rising edges at 5, 15, ...).
      at_time(1);
      check_eq("co_t0", int'(bus8.co), 0);
      check_eq("s_t0", int'(bus8.s), 0);
      check_eq("rst_co_q", int'(bus8.co_q), 0);
      check_eq("rst_co_rise", int'(bus8.co_rise), 0);
      check_eq("rst_cnt", int'(bus8.carry_cnt), 0);
      check_eq("rst_sat", int'(bus8.cnt_sat), 0);
      p0 = pulses8;
      bus8.a = 1'b1;
      reset  = 1'b0;
      at_time(6);
      check_eq("co_t5", int'(bus8.co), 0);
      check_eq("s_t5", int'(bus8.s), 1);
      at_time(10);
      check_eq("co_q_before", int'(bus8.co_q), 0);
      at_time(11);
      bus8.b = 1'b1;
      at_time(20);
      check_eq("co_q_rise", int'(bus8.co_q), 1);
      check_eq("co_rise_pulse", int'(bus8.co_rise), 1);
      check_eq("cnt_after_rise", int'(bus8.carry_cnt), 1);
      at_time(30);
      check_eq("co_rise_drop", int'(bus8.co_rise), 0);
      check_eq("co_q_hold", int'(bus8.co_q), 1);
      at_time(50);
      check_eq("co_t50", int'(bus8.co), 1);
      check_eq("s_t50", int'(bus8.s), 0);
      at_time(100);
      bus8.a = 1'b0;
      at_time(106);
      check_eq("co_t105", int'(bus8.co), 0);
      check_eq("s_t105", int'(bus8.s), 1);
      at_time(110);
      check_eq("co_q_fall", int'(bus8.co_q), 0);
      at_time(120);
      check_eq("cnt_end", int'(bus8.carry_cnt), 1);
      check_eq("pulse_total", pulses8 - p0, 1);

      for (int i = 0; i < 4; i++) begin
         bus8.a = i[1];
         bus8.b = i[0];
         #1;
         sum2 = i[1] + i[0];
         check_eq($sformatf("tt_co_%0d", i), int'(bus8.co), sum2 / 2);
         check_eq($sformatf("tt_s_%0d", i), int'(bus8.s), sum2 % 2);
      end

      // Saturation on the 2-bit counter instance.
      @(negedge clock);
      reset = 1'b1; bus2.a = 1'b0; bus2.b = 1'b0;
      #1;
      reset = 1'b0;
      bus2.a = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         bus2.b = 1'b1;
         @(negedge clock);
         bus2.b = 1'b0;
         @(negedge clock);
         check_eq($sformatf("sat_cnt_%0d", k), int'(bus2.carry_cnt), (k < 3) ? k : 3);
         check_eq($sformatf("sat_flag_%0d", k), int'(bus2.cnt_sat), (k >= 3) ? 1 : 0);
      end

      // Asynchronous reset between edges with the count at 2.
      @(negedge clock);
      reset = 1'b1; bus8.a = 1'b0; bus8.b = 1'b0;
      #1;
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus8.a = 1'b1; bus8.b = 1'b1;
         @(negedge clock);
         bus8.b = 1'b0;
         @(negedge clock);
      end
      check_eq("mid_cnt", int'(bus8.carry_cnt), 2);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check_eq("arst_co_q", int'(bus8.co_q), 0);
      check_eq("arst_co_rise", int'(bus8.co_rise), 0);
      check_eq("arst_cnt", int'(bus8.carry_cnt), 0);
      check_eq("arst_sat", int'(bus8.cnt_sat), 0);
      bus8.a = 1'b1; bus8.b = 1'b1;
      #1;
      check_eq("arst_co_comb", int'(bus8.co), 1);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_eq("post_co_q", int'(bus8.co_q), 1);
      check_eq("post_rise", int'(bus8.co_rise), 1);
      check_eq("post_cnt", int'(bus8.carry_cnt), 1);
      @(negedge clock);
      check_eq("post_rise_drop", int'(bus8.co_rise), 0);
      check_eq("post_cnt_hold", int'(bus8.carry_cnt), 1);
`else
      // Synchronizer latency: raw co immediate, co_q three edges later.
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      bus8.a = 1'b1; bus8.b = 1'b1;
      #1;
      check_eq("sync_co_now", int'(bus8.co), 1);
      for (int e = 1; e <= 3; e++) begin
         @(posedge clock);
         #1;
         check_eq($sformatf("sync_co_q_e%0d", e), int'(bus8.co_q), (e == 3) ? 1 : 0);
      end
      check_eq("sync_rise", int'(bus8.co_rise), 1);
      check_eq("sync_cnt", int'(bus8.carry_cnt), 1);
`endif

      // Randomized run against an edge-counting model of the sampled carry sequence.
      @(negedge clock);
      reset = 1'b1; bus8.a = 1'b0; bus8.b = 1'b0;
      #1;
      reset = 1'b0;
      m_coq = 0; m_rise = 0; total = 0;
      hist.delete();
`ifdef HALF_ADDER_IN_SYNC_EN
      hist.push_back(0);
      hist.push_back(0);
`endif
      for (int n = 0; n < 300; n++) begin
         @(negedge clock);
         exp_cnt = (total > 255) ? 255 : total;
         check_eq($sformatf("rnd_co_q_%0d", n), int'(bus8.co_q), m_coq);
         check_eq($sformatf("rnd_rise_%0d", n), int'(bus8.co_rise), m_rise);
         check_eq($sformatf("rnd_cnt_%0d", n), int'(bus8.carry_cnt), exp_cnt);
         check_eq($sformatf("rnd_sat_%0d", n), int'(bus8.cnt_sat), (exp_cnt == 255) ? 1 : 0);
         bus8.a = 1'($urandom_range(0, 1));
         bus8.b = 1'($urandom_range(0, 1));
         #1;
         sum2 = int'(bus8.a) + int'(bus8.b);
         check_eq($sformatf("rnd_co_%0d", n), int'(bus8.co), sum2 / 2);
         check_eq($sformatf("rnd_s_%0d", n), int'(bus8.s), sum2 % 2);
         c = sum2 / 2;
`ifdef HALF_ADDER_IN_SYNC_EN
         hist.push_back(c);
         eff = hist.pop_front();
`else
         eff = c;
`endif
         m_rise = (eff == 1 && m_coq == 0) ? 1 : 0;
         total  = total + m_rise;
         m_coq  = eff;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
